input_streaming: RTL and testbench

//  Feeds the NPU a 640x480 8-bit greyscale frame. Reads it from the 64-bit input image RAM, eight pixels per word.

---
 rtl/npu_io_pkg.sv | 22 ++
 rtl/pixel_word_unpacker.sv | 82 ++++++++
 rtl/input_streaming.sv | 140 ++++++++++++++
 tb/tb_input_streaming.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_io_pkg.sv
// npu_io_pkg: frame geometry and FSM states shared by the NPU
// streaming blocks (input_streaming, output_handling).
package npu_io_pkg;

  localparam int IMG_WIDTH       = 640;
  localparam int IMG_HEIGHT      = 480;
  localparam int PIX_PER_WORD    = 8;
  localparam int WORDS_PER_FRAME = IMG_WIDTH * IMG_HEIGHT / PIX_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } io_state_e;

  function automatic int words_per_frame(input int w, input int h);
    return w * h / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/pixel_word_unpacker.sv
// pixel_word_unpacker: shifts one 64-bit RAM word out a byte at a time.
// With INPUT_PREFETCH_EN defined it also holds the next word in a buffer.
module pixel_word_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        shift_i,
`ifdef INPUT_PREFETCH_EN
  input  logic        pf_req_i,
  output logic        buf_valid_o,
`endif
  input  logic [63:0] rd_data_i,
  output logic [7:0]  pixel_o,
  output logic [2:0]  byte_idx_o
);

  logic [63:0] shreg_q, shreg_d;
  logic [2:0]  idx_q, idx_d;

`ifdef INPUT_PREFETCH_EN
  logic [63:0] buf_q, buf_d;
  logic        vld_q, vld_d;
  logic        pend_q;
`endif

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
`ifdef INPUT_PREFETCH_EN
    buf_d = buf_q;
    vld_d = vld_q;
    // RAM data is valid the cycle after the prefetch read strobe
    if (pend_q) begin
      buf_d = rd_data_i;
      vld_d = 1'b1;
    end
`endif
    if (load_i) begin
      shreg_d = rd_data_i;
      idx_d   = 3'd0;
    end else if (shift_i) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
`ifdef INPUT_PREFETCH_EN
        shreg_d = buf_q;
        vld_d   = 1'b0;
`else
        shreg_d = {8'h00, shreg_q[63:8]};
`endif
      end else begin
        shreg_d = {8'h00, shreg_q[63:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
`ifdef INPUT_PREFETCH_EN
      buf_q   <= '0;
      vld_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
`ifdef INPUT_PREFETCH_EN
      buf_q   <= buf_d;
      vld_q   <= vld_d;
      pend_q  <= pf_req_i;
`endif
    end
  end

  assign pixel_o    = shreg_q[7:0];
  assign byte_idx_o = idx_q;
`ifdef INPUT_PREFETCH_EN
  assign buf_valid_o = vld_q;
`endif

endmodule

// File: rtl/input_streaming.sv
// input_streaming: streams a greyscale frame from the 64-bit image RAM
// into the NPU input FIFO. Define INPUT_PREFETCH_EN for 1 pixel/cycle.
module input_streaming #(
  parameter int IMG_WIDTH  = npu_io_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = npu_io_pkg::IMG_HEIGHT,
  parameter int BASE_ADDR  = 0,
  parameter int RAM_AW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [63:0]       ram_rd_data,
  input  logic              input_fifo_full,
  output logic              input_fifo_write_enable,
  output logic [31:0]       input_fifo_data,
  output logic              busy,
  output logic              done
);

  import npu_io_pkg::*;

  localparam int WORDS = words_per_frame(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [RAM_AW-1:0] BASE = RAM_AW'(BASE_ADDR);
  localparam logic [RAM_AW-1:0] LAST = RAM_AW'(BASE_ADDR + WORDS - 1);

  io_state_e         state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, shift, last_word, buf_ok;
  logic [7:0]        pixel;
  logic [2:0]        byte_idx;

`ifdef INPUT_PREFETCH_EN
  logic pf_req, buf_valid;
  // never leave a word before its successor has landed in the buffer
  assign buf_ok = (byte_idx != 3'd7) || last_word || buf_valid;
`else
  assign buf_ok = 1'b1;
`endif

  assign last_word = (addr_q == LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ram_rd_en = 1'b0;
    ram_addr  = '0;
    load  = 1'b0;
    shift = 1'b0;
    input_fifo_write_enable = 1'b0;
    input_fifo_data         = '0;
`ifdef INPUT_PREFETCH_EN
    pf_req = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          addr_d  = BASE;
        end
      end
      ST_FETCH: begin
        ram_rd_en = 1'b1;
        ram_addr  = addr_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        load    = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        shift = !input_fifo_full && buf_ok;
        input_fifo_write_enable = shift;
        input_fifo_data = {24'h0, pixel};
`ifdef INPUT_PREFETCH_EN
        if (shift && byte_idx == 3'd0 && !last_word) begin
          ram_rd_en = 1'b1;
          ram_addr  = addr_q + 1'b1;
          pf_req    = 1'b1;
        end
`endif
        if (shift && byte_idx == 3'd7) begin
          if (last_word) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
`ifndef INPUT_PREFETCH_EN
            state_d = ST_FETCH;
`endif
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  pixel_word_unpacker u_unpack (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .shift_i    (shift),
`ifdef INPUT_PREFETCH_EN
    .pf_req_i   (pf_req),
    .buf_valid_o(buf_valid),
`endif
    .rd_data_i  (ram_rd_data),
    .pixel_o    (pixel),
    .byte_idx_o (byte_idx)
  );

endmodule

// File: tb/tb_input_streaming.sv
// tb_input_streaming: directed + randomized checks of input_streaming
// on a reduced 32x4 frame against a byte-level reference of the RAM.
module tb_input_streaming;

  localparam int W    = 32;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int NW   = W * H / 8;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          input_fifo_full = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [63:0]   ram_rd_data = '0;
  logic          input_fifo_write_enable;
  logic [31:0]   input_fifo_data;
  logic          busy, done;

  logic [63:0] ram [NW];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int s_cyc = 0;
  int wq[$];
  int wc[$];
  int rq[$];

  input_streaming #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .BASE_ADDR (0),
    .RAM_AW    (AW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .ram_addr               (ram_addr),
    .ram_rd_en              (ram_rd_en),
    .ram_rd_data            (ram_rd_data),
    .input_fifo_full        (input_fifo_full),
    .input_fifo_write_enable(input_fifo_write_enable),
    .input_fifo_data        (input_fifo_data),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_rd_data <= ram[int'(ram_addr) % NW];
  end

  always @(negedge clk) begin
    if (input_fifo_write_enable && !input_fifo_full) begin
      wq.push_back(int'(input_fifo_data));
      wc.push_back(cyc);
    end
    if (ram_rd_en) rq.push_back(int'(ram_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int exp_pixel(input int p);
    logic [63:0] w;
    w = ram[p / 8];
    return int'((w >> (8 * (p % 8))) & 64'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq.delete();
    wc.delete();
    rq.delete();
  endtask

  task automatic fill_ramp();
    for (int w = 0; w < NW; w++)
      for (int k = 0; k < 8; k++)
        ram[w][8*k +: 8] = 8'((8 * w + k + 1) & 255);
  endtask

  task automatic fill_rand();
    for (int w = 0; w < NW; w++) ram[w] = {$urandom, $urandom};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_writes(input int k, input string tag);
    int n = 0;
    while (wq.size() < k && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
  endtask

  task automatic run_frame(input int pct, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      input_fifo_full = ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end
    input_fifo_full = 1'b0;
    chk("frame_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic check_stream(input string tag);
    int bad = 0;
    chk({tag, "_count"}, 64'(wq.size()), 64'(NPIX));
    for (int i = 0; i < NPIX; i++)
      if (qget(wq, i) != exp_pixel(i)) bad++;
    chk({tag, "_bad_pixels"}, 64'(bad), 64'd0);
    chk({tag, "_last_addr"}, 64'(qget(rq, rq.size() - 1)), 64'(NW - 1));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int exp_last;
`ifdef INPUT_PREFETCH_EN
    exp_last = NPIX + 2;
`else
    exp_last = 10 * NW;
`endif
    fill_ramp();

    // reset held 3 cycles with start asserted
    reset = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs",
          {ram_addr, ram_rd_en, input_fifo_write_enable,
           input_fifo_data, busy, done}, 64'd0);
    end
    tick();
    start = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rd_en", 64'(ram_rd_en), 64'd0);

    // unstalled frame, ramp data
    clear_q();
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    run_frame(0, 400);
    for (int i = 0; i < 8; i++) chk("word0_byte", 64'(qget(wq, i)), 64'(i + 1));
    chk("first_wr_cycle", 64'(qget(wc, 0) - s_cyc), 64'd3);
    chk("rd_addr0", 64'(qget(rq, 0)), 64'd0);
    chk("rd_addr1", 64'(qget(rq, 1)), 64'd1);
    chk("last_wr_cycle", 64'(qget(wc, NPIX - 1) - s_cyc), 64'(exp_last));
    check_stream("plain");

    // five stalled cycles after the third byte
    clear_q();
    pulse_start();
    wait_writes(3, "stall_reach");
    input_fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_we", 64'(input_fifo_write_enable && !input_fifo_full), 64'd0);
      chk("stall_data", 64'(input_fifo_data), 64'h04);
      tick();
    end
    input_fifo_full = 1'b0;
    run_frame(0, 400);
    check_stream("stall");

    // random data, 30% backpressure
    fill_rand();
    clear_q();
    pulse_start();
    run_frame(30, 3000);
    check_stream("rand");
    repeat (5) tick();
    chk("done_sticky", 64'(done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);

    // start pulse mid-frame is ignored
    clear_q();
    pulse_start();
    wait_writes(20, "mid_reach");
    pulse_start();
    run_frame(0, 400);
    check_stream("midstart");

    // reset mid-frame then restart
    fill_ramp();
    clear_q();
    pulse_start();
    wait_writes(40, "rst_reach");
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_we", 64'(input_fifo_write_enable), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    clear_q();
    pulse_start();
    chk("restart_done", 64'(done), 64'd0);
    wait_writes(1, "restart_reach");
    chk("restart_pixel", 64'(qget(wq, 0)), 64'h01);
    chk("restart_addr", 64'(qget(rq, 0)), 64'd0);
    run_frame(0, 400);
    check_stream("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
